// File: rtl/mem_cache_ctrl.sv
// MEM-stage load/store responder: 2-way set-associative write-through cache in front of SRAM.
// Define MEM_CACHE_STATS_EN to add saturating hit/miss counters.
module mem_cache_ctrl #(
    parameter int unsigned SETS     = 64,
    parameter int unsigned TAG_W    = 10,
    parameter int unsigned MEM_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
`ifdef MEM_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned INDEX_W = $clog2(SETS);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t state;

    logic [31:0]        a;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               ws;

    logic [SETS-1:0]    valid0;
    logic [SETS-1:0]    valid1;
    logic [SETS-1:0]    lru;
    logic [TAG_W-1:0]   tag_mem  [2][SETS];
    logic [63:0]        data_mem [2][SETS];

    logic        hit0, hit1, hit, hw, fw, is_rd;
    logic [63:0] hit_line;

    assign a   = address - MEM_BASE;
    assign ws  = a[2];
    assign idx = a[INDEX_W+2:3];
    assign tag = a[INDEX_W+TAG_W+2:INDEX_W+3];

    assign hit0  = valid0[idx] && (tag_mem[0][idx] == tag);
    assign hit1  = valid1[idx] && (tag_mem[1][idx] == tag);
    assign hit   = hit0 | hit1;
    // way 0 takes priority on a double match
    assign hw    = ~hit0;
    assign fw    = lru[idx];
    assign is_rd = mem_r_en & ~mem_w_en;

    assign hit_line = hw ? data_mem[1][idx] : data_mem[0][idx];

    always_comb begin
        rdata = '0;
        ready = 1'b1;
        unique case (state)
            IDLE: begin
                if (mem_w_en) begin
                    ready = 1'b0;
                end else if (mem_r_en) begin
                    ready = hit;
                    if (hit) rdata = ws ? hit_line[63:32] : hit_line[31:0];
                end
            end
            RD_MISS: begin
                ready = sram_ready;
                if (sram_ready) rdata = ws ? sram_rdata[63:32] : sram_rdata[31:0];
            end
            WR: ready = sram_ready;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            valid0     <= '0;
            valid1     <= '0;
            lru        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_w_en) begin
                        state      <= WR;
                        sram_req   <= 1'b1;
                        sram_we    <= 1'b1;
                        sram_addr  <= a;
                        sram_wdata <= wdata;
                        if (hit) lru[idx] <= ~hw;
                    end else if (mem_r_en) begin
                        if (hit) begin
                            lru[idx] <= ~hw;
                        end else begin
                            state     <= RD_MISS;
                            sram_req  <= 1'b1;
                            sram_we   <= 1'b0;
                            sram_addr <= {a[31:3], 3'b000};
                        end
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        state    <= IDLE;
                        sram_req <= 1'b0;
                        if (fw) valid1[idx] <= 1'b1;
                        else    valid0[idx] <= 1'b1;
                        lru[idx] <= ~fw;
                    end
                end
                WR: begin
                    if (sram_ready) begin
                        state    <= IDLE;
                        sram_req <= 1'b0;
                        sram_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // tag/data arrays need no reset; valid bits gate them
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_w_en && hit) begin
            if (ws) data_mem[hw][idx][63:32] <= wdata;
            else    data_mem[hw][idx][31:0]  <= wdata;
        end
        if (state == RD_MISS && sram_ready) begin
            tag_mem[fw][idx]  <= tag;
            data_mem[fw][idx] <= sram_rdata;
        end
    end

`ifdef MEM_CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && is_rd) begin
            if (hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Bench for mem_cache_ctrl: SRAM model with fixed latency, read scoreboard,
// latency and SRAM-side checks.
module tb_mem_cache_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_req, sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
`ifdef MEM_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int cnt;

    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];

    mem_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
`ifdef MEM_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    assign sram_rdata = {mem[{sram_addr[11:3], 1'b1}],
                         mem[{sram_addr[11:3], 1'b0}]};

    // SRAM model: pulse sram_ready after LAT request cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 0;
            sram_ready <= 1'b0;
        end else begin
            sram_ready <= 1'b0;
            if (sram_req && !sram_ready) begin
                if (cnt == LAT - 1) begin
                    sram_ready <= 1'b1;
                    cnt        <= 0;
                    if (sram_we) mem[sram_addr[11:2]] <= sram_wdata;
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                cnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // read completions are popped from the scoreboard here
    always @(negedge clk) begin
        if (!rst && mem_r_en && !mem_w_en && ready) begin
            if (exp_q.size() == 0) begin
                check("rdata_unexpected", rdata, 32'hx);
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic access(input logic we, input logic both,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_hit);
        int lows;
        logic c_req, c_we;
        logic [31:0] c_addr, c_wdata, rel;
        rel = addr - 32'd1024;
        @(posedge clk);
        #1;
        address  = addr;
        wdata    = data;
        mem_w_en = we;
        mem_r_en = !we || both;
        if (!we) begin
            exp_q.push_back(mem[rel[11:2]]);
            if (exp_hit) exp_hits++;
            else         exp_misses++;
        end
        lows  = 0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        @(negedge clk);
        while (!ready && lows < 50) begin
            lows++;
            @(negedge clk);
            if (lows == 1) begin
                c_req = sram_req; c_we = sram_we;
                c_addr = sram_addr; c_wdata = sram_wdata;
            end
        end
        check("stall_cycles", lows, (exp_hit && !we) ? 0 : 1 + LAT);
        if (we || !exp_hit) begin
            check("sram_req", {31'd0, c_req}, 32'd1);
            check("sram_we", {31'd0, c_we}, {31'd0, we});
            check("sram_addr", c_addr, we ? rel : {rel[31:3], 3'b000});
            if (we) check("sram_wdata", c_wdata, data);
        end
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic exp_hit);
        access(1'b0, 1'b0, addr, 32'd0, exp_hit);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        access(1'b1, 1'b0, addr, data, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5000000 + i;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
        address = '0; wdata = '0;
        #23;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_req", {31'd0, sram_req}, 32'd0);
        check("rst_addr", sram_addr, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_rdata", rdata, 32'd0);
        check("idle_req", {31'd0, sram_req}, 32'd0);

        rd(32'h400, 1'b0);
        rd(32'h404, 1'b1);
        rd(32'h600, 1'b0);
        rd(32'h400, 1'b1);
        rd(32'h800, 1'b0);
        rd(32'h400, 1'b1);
        rd(32'h600, 1'b0);
        wr(32'h400, 32'hDEADBEEF);
        rd(32'h400, 1'b1);
        wr(32'h1000, 32'hCAFEF00D);
        rd(32'h1000, 1'b0);
        access(1'b1, 1'b1, 32'h404, 32'h5555AAAA, 1'b0);
        rd(32'h404, 1'b1);
`ifdef MEM_CACHE_STATS_EN
        check("hit_count", {16'd0, hit_count}, exp_hits);
        check("miss_count", {16'd0, miss_count}, exp_misses);
`endif

        // reset in the middle of a read miss
        @(posedge clk);
        #1;
        address  = 32'h480;
        mem_r_en = 1'b1;
        repeat (2) @(negedge clk);
        check("miss_req", {31'd0, sram_req}, 32'd1);
        #1;
        rst      = 1'b1;
        mem_r_en = 1'b0;
        #1;
        check("rstmid_req", {31'd0, sram_req}, 32'd0);
        check("rstmid_ready", {31'd0, ready}, 32'd1);
        check("rstmid_rdata", rdata, 32'd0);
`ifdef MEM_CACHE_STATS_EN
        check("rst_hit_count", {16'd0, hit_count}, 32'd0);
        check("rst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        rd(32'h400, 1'b0);
        rd(32'h404, 1'b1);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
